// File: rtl/pcihellocore_button_pio_irq.sv
// Avalon-MM button PIO: 2-flop sync, per-bit debounce, W1C edge capture, maskable level irq.
// Optional BUTTON_DEBOUNCE_EN: when undefined the debounce counters are removed and DATA tracks RAW.
module pcihellocore_button_pio_irq #(
    parameter int unsigned      WIDTH           = 4,
    parameter int unsigned      DEBOUNCE_CYCLES = 50000,
    parameter int unsigned      EDGE_TYPE       = 1,
    parameter logic [WIDTH-1:0] IRQ_MASK_RESET  = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);

    localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

    logic [WIDTH-1:0] r_sync1;
    logic [WIDTH-1:0] r_raw;
    logic [WIDTH-1:0] r_deb;
    logic [WIDTH-1:0] r_edge;
    logic [WIDTH-1:0] r_mask;
    logic [WIDTH-1:0] w_commit;
    logic [WIDTH-1:0] w_set;
    logic [WIDTH-1:0] w_clr;
    logic [31:0]      w_rd_mux;
    logic             w_wr;
    logic             w_unused;

    // Two-flop synchroniser; second stage is the RAW view.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync1 <= '0;
            r_raw   <= '0;
        end else begin
            r_sync1 <= in_port;
            r_raw   <= r_sync1;
        end
    end

`ifdef BUTTON_DEBOUNCE_EN
    logic [CNT_W-1:0] r_cnt [WIDTH];

    // Commit only once RAW has differed from deb for DEBOUNCE_CYCLES consecutive cycles.
    always_comb begin
        w_commit = '0;
        for (int i = 0; i < int'(WIDTH); i++) begin
            w_commit[i] = (r_raw[i] != r_deb[i]) && (r_cnt[i] == CNT_W'(DEBOUNCE_CYCLES - 1));
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < int'(WIDTH); i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < int'(WIDTH); i++) begin
                if ((r_raw[i] == r_deb[i]) || w_commit[i]) begin
                    r_cnt[i] <= '0;
                end else begin
                    r_cnt[i] <= r_cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    assign w_unused = ^writedata;
`else
    assign w_commit = r_raw ^ r_deb;
    assign w_unused = ^{writedata, 32'(DEBOUNCE_CYCLES), 32'(CNT_W)};
`endif

    // A commit always flips deb toward RAW.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_deb <= '0;
        end else begin
            r_deb <= r_deb ^ w_commit;
        end
    end

    // Select which committed transitions are captured, and decode the W1C strobe.
    always_comb begin
        w_set = '0;
        w_clr = '0;
        w_wr  = chipselect && !write_n;
        if (EDGE_TYPE == 0) begin
            w_set = w_commit & r_raw;
        end else if (EDGE_TYPE == 1) begin
            w_set = w_commit & ~r_raw;
        end else begin
            w_set = w_commit;
        end
        if (w_wr && (address == 2'd3)) begin
            w_clr = writedata[WIDTH-1:0];
        end
    end

    // Capture, mask and interrupt registers; a set beats a same-cycle clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_edge <= '0;
            r_mask <= IRQ_MASK_RESET;
            irq    <= 1'b0;
        end else begin
            r_edge <= (r_edge & ~w_clr) | w_set;
            if (w_wr && (address == 2'd2)) begin
                r_mask <= writedata[WIDTH-1:0];
            end
            irq <= |(r_edge & r_mask);
        end
    end

    always_comb begin
        w_rd_mux = '0;
        case (address)
            2'd0:    w_rd_mux = 32'(r_deb);
            2'd1:    w_rd_mux = 32'(r_raw);
            2'd2:    w_rd_mux = 32'(r_mask);
            default: w_rd_mux = 32'(r_edge);
        endcase
    end

    // Reads need no chipselect and see pre-write register values.
    always_ff @(posedge clk) begin
        if (reset) begin
            readdata <= '0;
        end else begin
            readdata <= w_rd_mux;
        end
    end

endmodule
